rtc_bus_driver: RTL and testbench

Bus-cycle engine between the RTC register block and the external real-time-clock chip. It takes single-byte read/write requests (register address plus data) and performs the chip's multiplexed address/data bus protocol: an address cycle, then a data cycle, each with programmable setup, strobe and hold times. It returns read data and a one-cycle completion pulse, so the register stage can sequence whole date/time/timer transfers one byte at a time.

---
 rtl/rtc_bus_driver.sv | 243 ++++++++++++++++++++++++
 tb/tb_rtc_bus_driver.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_driver.sv
`default_nettype none
// ============================================================================
// Module   : rtc_bus_driver
// Purpose  : Bus-cycle engine for an external real-time-clock chip that uses
//            a multiplexed address/data bus. It runs one single-byte read or
//            write per request: an address cycle, then a data cycle. Each
//            cycle has a programmable setup, strobe and hold time.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            req/we/addr/wdata - request side (sampled only when idle)
//            rdata/busy/done - read data, in-progress flag, completion pulse
//            cs_n/ad_n/rd_n/wr_n/ad_out/ad_oe - registered chip bus outputs
//            ad_in           - AD bus value seen at the pad
// Revision : 1.0 - initial release
// ============================================================================
module rtc_bus_driver #(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       cs_n,
    output logic       ad_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam logic [3:0] c_setup_ld  = 4'(T_SETUP - 1);
    localparam logic [3:0] c_strobe_ld = 4'(T_STROBE - 1);
    localparam logic [3:0] c_hold_ld   = 4'(T_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_A_SETUP  = 3'd1,
        S_A_STROBE = 3'd2,
        S_A_HOLD   = 3'd3,
        S_D_SETUP  = 3'd4,
        S_D_STROBE = 3'd5,
        S_D_HOLD   = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       w_accept;

    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_we;

    // Values the transaction will use after this edge. On the accept edge
    // the request inputs are used directly so the first registered bus
    // cycle already carries the new address.
    logic [7:0] w_addr_n;
    logic [7:0] w_wdata_n;
    logic       w_we_n;

    logic       w_cs_n;
    logic       w_ad_n;
    logic       w_rd_n;
    logic       w_wr_n;
    logic [7:0] w_ad_out;
    logic       w_ad_oe;
    logic       w_busy;
    logic       w_done;
    logic       w_rd_capture;

    // ------------------------------------------------------------------
    // Next-state and phase counter. Each timed state loads N-1 on entry
    // and advances once the counter has counted down to zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_accept     = 1'b1;
                    w_state_next = S_A_SETUP;
                    w_cnt_next   = c_setup_ld;
                end
            end
            S_A_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_A_STROBE;
                    w_cnt_next   = c_strobe_ld;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_A_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_A_HOLD;
                    w_cnt_next   = c_hold_ld;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_A_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_D_SETUP;
                    w_cnt_next   = c_setup_ld;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_D_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_D_STROBE;
                    w_cnt_next   = c_strobe_ld;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_D_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_D_HOLD;
                    w_cnt_next   = c_hold_ld;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_D_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                // Requests arriving here are dropped, not queued.
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_addr_n  = w_accept ? addr  : r_addr;
    assign w_wdata_n = w_accept ? wdata : r_wdata;
    assign w_we_n    = w_accept ? we    : r_we;

    // Read data is taken on the final strobe cycle, while rd_n is still low.
    assign w_rd_capture = (r_state == S_D_STROBE) && (r_cnt == 4'd0) && !r_we;

    // ------------------------------------------------------------------
    // Bus outputs decoded from the next state so that every pin comes
    // straight from a flop: no strobe glitches and no cycle of lag.
    // ------------------------------------------------------------------
    always_comb begin
        w_cs_n   = 1'b1;
        w_ad_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_ad_out = 8'h00;
        w_ad_oe  = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        unique case (w_state_next)
            S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
                w_cs_n   = 1'b0;
                w_ad_n   = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = w_addr_n;
                w_busy   = 1'b1;
                // The chip latches the address on a write strobe even
                // when the data cycle that follows is a read.
                w_wr_n   = (w_state_next != S_A_STROBE);
            end
            S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
                w_cs_n = 1'b0;
                w_busy = 1'b1;
                if (w_we_n) begin
                    w_ad_oe  = 1'b1;
                    w_ad_out = w_wdata_n;
                    w_wr_n   = (w_state_next != S_D_STROBE);
                end else begin
                    // Bus released for the whole data cycle so the chip
                    // never fights our driver while rd_n is low.
                    w_rd_n = (w_state_next != S_D_STROBE);
                end
            end
            S_DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_we    <= 1'b0;
            rdata   <= 8'h00;
            cs_n    <= 1'b1;
            ad_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            ad_out  <= 8'h00;
            ad_oe   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_addr  <= w_addr_n;
            r_wdata <= w_wdata_n;
            r_we    <= w_we_n;
            if (w_rd_capture) begin
                rdata <= ad_in;
            end
            cs_n    <= w_cs_n;
            ad_n    <= w_ad_n;
            rd_n    <= w_rd_n;
            wr_n    <= w_wr_n;
            ad_out  <= w_ad_out;
            ad_oe   <= w_ad_oe;
            busy    <= w_busy;
            done    <= w_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtc_bus_driver
// Purpose  : Self-checking bench for rtc_bus_driver. Two instances are run:
//            one with default timing (2/4/2) and one with 1/1/1 timing.
//            Expected bus values per cycle are computed from the cycle
//            number alone (window arithmetic), not from any state machine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-timing instance
    logic       rst_d, req_d, we_d;
    logic [7:0] addr_d, wdata_d, rdata_d, ad_out_d, ad_in_d, rv_d;
    logic       busy_d, done_d, cs_n_d, ad_n_d, rd_n_d, wr_n_d, ad_oe_d;

    // Fast-timing instance
    logic       rst_f, req_f, we_f;
    logic [7:0] addr_f, wdata_f, rdata_f, ad_out_f, ad_in_f, rv_f;
    logic       busy_f, done_f, cs_n_f, ad_n_f, rd_n_f, wr_n_f, ad_oe_f;

    // Chip model: drives the read value only while the read strobe is low.
    assign ad_in_d = rd_n_d ? 8'hEE : rv_d;
    assign ad_in_f = rd_n_f ? 8'hEE : rv_f;

    rtc_bus_driver dut_d (
        .clk(clk), .reset(rst_d), .req(req_d), .we(we_d), .addr(addr_d),
        .wdata(wdata_d), .rdata(rdata_d), .busy(busy_d), .done(done_d),
        .cs_n(cs_n_d), .ad_n(ad_n_d), .rd_n(rd_n_d), .wr_n(wr_n_d),
        .ad_out(ad_out_d), .ad_oe(ad_oe_d), .ad_in(ad_in_d)
    );

    rtc_bus_driver #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1)) dut_f (
        .clk(clk), .reset(rst_f), .req(req_f), .we(we_f), .addr(addr_f),
        .wdata(wdata_f), .rdata(rdata_f), .busy(busy_f), .done(done_f),
        .cs_n(cs_n_f), .ad_n(ad_n_f), .rd_n(rd_n_f), .wr_n(wr_n_f),
        .ad_out(ad_out_f), .ad_oe(ad_oe_f), .ad_in(ad_in_f)
    );

    typedef struct packed {
        logic       cs_n;
        logic       ad_n;
        logic       rd_n;
        logic       wr_n;
        logic       ad_oe;
        logic       busy;
        logic       done;
        logic [7:0] ad_out;
    } bus_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_rd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bus_t snap(input bit fast);
        bus_t s;
        s.cs_n   = fast ? cs_n_f   : cs_n_d;
        s.ad_n   = fast ? ad_n_f   : ad_n_d;
        s.rd_n   = fast ? rd_n_f   : rd_n_d;
        s.wr_n   = fast ? wr_n_f   : wr_n_d;
        s.ad_oe  = fast ? ad_oe_f  : ad_oe_d;
        s.busy   = fast ? busy_f   : busy_d;
        s.done   = fast ? done_f   : done_d;
        s.ad_out = fast ? ad_out_f : ad_out_d;
        return s;
    endfunction

    function automatic logic [7:0] get_rdata(input bit fast);
        return fast ? rdata_f : rdata_d;
    endfunction

    // Expected pins in cycle k after the accept edge (k=0: idle/reset).
    function automatic bus_t model(input int k, input int ts, input int tst, input int th,
                                   input bit w, input logic [7:0] a, input logic [7:0] d);
        bus_t m;
        int   len;
        int   half;
        int   j;
        bit   strobe;
        len  = 2 * (ts + tst + th);
        half = len / 2;
        m    = '{cs_n: 1'b1, ad_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, ad_oe: 1'b0,
                 busy: 1'b0, done: 1'b0, ad_out: 8'h00};
        if (k >= 1 && k <= len) begin
            m.busy = 1'b1;
            m.cs_n = 1'b0;
            j      = (k > half) ? k - half : k;
            strobe = (j > ts) && (j <= ts + tst);
            if (k <= half) begin
                m.ad_n   = 1'b0;
                m.ad_oe  = 1'b1;
                m.ad_out = a;
                m.wr_n   = !strobe;
            end else if (w) begin
                m.ad_oe  = 1'b1;
                m.ad_out = d;
                m.wr_n   = !strobe;
            end else begin
                m.rd_n = !strobe;
            end
        end else if (k == len + 1) begin
            m.done = 1'b1;
        end
        return m;
    endfunction

    task automatic drive(input bit fast, input bit r, input bit w,
                         input logic [7:0] a, input logic [7:0] d);
        if (fast) begin
            req_f = r; we_f = w; addr_f = a; wdata_f = d;
        end else begin
            req_d = r; we_d = w; addr_d = a; wdata_d = d;
        end
    endtask

    task automatic set_rst(input bit fast, input bit v);
        if (fast) rst_f = v;
        else      rst_d = v;
    endtask

    // Runs one transaction starting at #1 after an edge. Returns at #1 into
    // the first idle cycle (L+2) with the next edge's inputs already set.
    // keep_req: req stays high with scrambled addr/data during the transfer.
    // poke_done: req is raised during DONE only. abort_k: reset in cycle k.
    task automatic run_txn(input string name, input bit fast, input bit w,
                           input logic [7:0] a, input logic [7:0] d, input logic [7:0] rv,
                           input bit keep_req, input bit poke_done, input int abort_k);
        int   ts, tst, th, len;
        bus_t obs_b, exp_b;
        ts  = fast ? 1 : 2;
        tst = fast ? 1 : 4;
        th  = fast ? 1 : 2;
        len = 2 * (ts + tst + th);
        drive(fast, 1'b1, w, a, d);
        if (fast) rv_f = rv;
        else      rv_d = rv;
        @(posedge clk); #1;
        for (int k = 1; k <= len + 2; k++) begin
            obs_b = snap(fast);
            exp_b = model(k, ts, tst, th, w, a, d);
            if (!exp_b.ad_oe) begin
                obs_b.ad_out = 8'h00;
                exp_b.ad_out = 8'h00;
            end
            chk($sformatf("%s bus k=%0d", name, k), 32'(obs_b), 32'(exp_b));
            chk($sformatf("%s strobes k=%0d", name, k), 32'(obs_b.rd_n | obs_b.wr_n), 32'd1);
            chk($sformatf("%s oe_vs_rd k=%0d", name, k), 32'(obs_b.ad_oe & ~obs_b.rd_n), 32'd0);
            if (!w && k == len + 1) exp_rd[fast] = rv;
            if (w || k > len)
                chk($sformatf("%s rdata k=%0d", name, k), 32'(get_rdata(fast)), 32'(exp_rd[fast]));
            if (k == abort_k) begin
                set_rst(fast, 1'b1);
                @(posedge clk); #1;
                exp_rd[fast] = 8'h00;
                chk($sformatf("%s abort bus", name), 32'(snap(fast)),
                    32'(model(0, ts, tst, th, w, a, d)));
                chk($sformatf("%s abort rdata", name), 32'(get_rdata(fast)), 32'd0);
                set_rst(fast, 1'b0);
                drive(fast, 1'b0, 1'b0, 8'h00, 8'h00);
                return;
            end
            if (keep_req)
                drive(fast, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
            else if (poke_done && k == len + 1)
                drive(fast, 1'b1, 1'($urandom), 8'($urandom), 8'($urandom));
            else
                drive(fast, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
            if (k < len + 2) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        rv_d = 8'h00;
        rv_f = 8'h00;
        rst_d = 1'b1;
        rst_f = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        for (int f = 0; f < 2; f++) begin
            chk($sformatf("reset bus dut%0d", f), 32'(snap(f[0])),
                32'(model(0, 1, 1, 1, 1'b0, 8'h00, 8'h00)));
            chk($sformatf("reset rdata dut%0d", f), 32'(get_rdata(f[0])), 32'd0);
        end
        rst_d = 1'b0;
        rst_f = 1'b0;
        @(posedge clk); #1;

        // Directed default-timing sequence
        run_txn("wr21", 1'b0, 1'b1, 8'h21, 8'h45, 8'h00, 1'b0, 1'b0, 0);
        run_txn("rd22", 1'b0, 1'b0, 8'h22, 8'h00, 8'h59, 1'b0, 1'b0, 0);
        run_txn("wr_hold", 1'b0, 1'b1, 8'h33, 8'hA7, 8'h00, 1'b0, 1'b0, 0);
        // req held high: one transaction every L+2 cycles
        run_txn("keep0", 1'b0, 1'b1, 8'h40, 8'h01, 8'h00, 1'b1, 1'b0, 0);
        run_txn("keep1", 1'b0, 1'b0, 8'h41, 8'h02, 8'h6C, 1'b1, 1'b0, 0);
        run_txn("keep2", 1'b0, 1'b1, 8'h42, 8'h03, 8'h00, 1'b1, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        // reset in cycle 12 of a write, then a full recovery write
        run_txn("abort", 1'b0, 1'b1, 8'h50, 8'h5A, 8'h00, 1'b0, 1'b0, 12);
        @(posedge clk); #1;
        run_txn("recover", 1'b0, 1'b1, 8'h51, 8'hC3, 8'h00, 1'b0, 1'b0, 0);
        // write then read, with a req poke during DONE that must be ignored
        run_txn("b2b_wr", 1'b0, 1'b1, 8'h60, 8'h9E, 8'h00, 1'b0, 1'b1, 0);
        @(posedge clk); #1;
        chk("poke ignored busy", 32'(busy_d), 32'd0);
        chk("poke ignored cs_n", 32'(cs_n_d), 32'd1);
        run_txn("b2b_rd", 1'b0, 1'b0, 8'h61, 8'h00, 8'h3D, 1'b0, 1'b0, 0);

        // Fast-timing instance
        run_txn("f_wr10", 1'b1, 1'b1, 8'h10, 8'h07, 8'h00, 1'b0, 1'b0, 0);
        run_txn("f_rd", 1'b1, 1'b0, 8'h11, 8'h00, 8'hB4, 1'b0, 1'b0, 0);
        run_txn("f_keep0", 1'b1, 1'b0, 8'h12, 8'h00, 8'h81, 1'b1, 1'b0, 0);
        run_txn("f_keep1", 1'b1, 1'b1, 8'h13, 8'h77, 8'h00, 1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;

        // Randomized transactions on both instances
        for (int i = 0; i < 24; i++) begin
            bit fast;
            fast = i[0];
            run_txn($sformatf("rnd%0d", i), fast, 1'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 0);
            drive(fast, 1'b0, 1'b0, 8'h00, 8'h00);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            // drop any in-flight held request before the next pick
            if (busy_d || busy_f) begin
                repeat (20) @(posedge clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
